// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: derives PC control and
// per-stage enable/flush from stage fields, with sticky halt and event counters.
module pipeline_hazard_ctrl #(
  parameter int LU_CYCLES = 1,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_MemtoReg,
  input  logic             ex_RegWr,
  input  logic [4:0]       ex_WrDest,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_beq,
  input  logic             mem_bne,
  input  logic             mem_zero,
  input  logic             mem_jump,
  input  logic             mem_jreg,
  input  logic             wb_Halt,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DWAIT   = 2'd1,
    LUSTALL = 2'd2,
    HALTED  = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [2:0]       lu_cnt_r, lu_cnt_s;
  logic             halt_r, halt_set_s, flush_evt_s, stall_evt_s;
  logic             redirect_s, dreq_s, lu_haz_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  // Hazard and request decode from the stage fields
  assign redirect_s = (mem_beq & mem_zero) | (mem_bne & ~mem_zero) | mem_jump | mem_jreg;
  assign dreq_s     = mem_dREN | mem_dWEN;
  assign lu_haz_s   = ex_MemtoReg & ex_RegWr & (ex_WrDest != 5'd0) &
                      ((ex_WrDest == id_rs) | (id_uses_rt & (ex_WrDest == id_rt)));

  // Prioritised next-state and enable/flush selection
  always_comb begin
    state_s     = state_r;
    lu_cnt_s    = lu_cnt_r;
    halt_set_s  = 1'b0;
    flush_evt_s = 1'b0;
    pc_en       = 1'b0;
    pc_redirect = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (state_r == HALTED) begin
      state_s = HALTED;
    end else if (wb_Halt) begin
      state_s    = HALTED;
      halt_set_s = 1'b1;
    end else if ((state_r == DWAIT) || ((state_r == RUN) && dreq_s && !dhit)) begin
      if ((state_r == DWAIT) && dhit) begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
        // A load-use pair released by the data access gets the full bubble count
        if (lu_haz_s) begin
          state_s  = LUSTALL;
          lu_cnt_s = 3'(LU_CYCLES);
        end else begin
          state_s = RUN;
        end
      end else begin
        memwb_en    = 1'b1;
        memwb_flush = 1'b1;
        state_s     = DWAIT;
      end
    end else if (redirect_s) begin
      pc_en       = 1'b1;
      pc_redirect = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      exmem_en    = 1'b1;
      memwb_en    = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      flush_evt_s = 1'b1;
      lu_cnt_s    = 3'd0;
      state_s     = RUN;
    end else if ((state_r == LUSTALL) || lu_haz_s) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      if (state_r == LUSTALL) begin
        if (lu_cnt_r > 3'd1) begin
          lu_cnt_s = lu_cnt_r - 3'd1;
          state_s  = LUSTALL;
        end else begin
          lu_cnt_s = 3'd0;
          state_s  = RUN;
        end
      end else begin
        lu_cnt_s = 3'(LU_CYCLES - 1);
        state_s  = (LU_CYCLES > 1) ? LUSTALL : RUN;
      end
    end else if (!ihit) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      state_s    = RUN;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      state_s  = RUN;
    end
  end

  assign stall_evt_s = !pc_en && (state_r != HALTED);

  // State, sticky halt and saturating event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= RUN;
      lu_cnt_r    <= 3'd0;
      halt_r      <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      state_r  <= state_s;
      lu_cnt_r <= lu_cnt_s;
      halt_r   <= halt_r | halt_set_s;
      if (stall_evt_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_evt_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign halt      = halt_r;
  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (LU_CYCLES=1/CNT_W=32 and
// LU_CYCLES=3/CNT_W=4) driven in lockstep and checked against a flag-based model.
module tb_pipeline_hazard_ctrl;

  logic CLK, RST, ihit, dhit, id_uses_rt, ex_MemtoReg, ex_RegWr;
  logic [4:0] id_rs, id_rt, ex_WrDest;
  logic mem_dREN, mem_dWEN, mem_beq, mem_bne, mem_zero, mem_jump, mem_jreg, wb_Halt;

  logic pc_en0, pc_redirect0, ifid_en0, idex_en0, exmem_en0, memwb_en0;
  logic ifid_flush0, idex_flush0, exmem_flush0, memwb_flush0, halt0;
  logic [31:0] stall_cnt0, flush_cnt0;
  logic pc_en1, pc_redirect1, ifid_en1, idex_en1, exmem_en1, memwb_en1;
  logic ifid_flush1, idex_flush1, exmem_flush1, memwb_flush1, halt1;
  logic [3:0] stall_cnt1, flush_cnt1;

  int vectors = 0;
  int miscompares = 0;

  pipeline_hazard_ctrl #(.LU_CYCLES(1), .CNT_W(32)) dut0 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr),
    .ex_WrDest(ex_WrDest), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_beq(mem_beq),
    .mem_bne(mem_bne), .mem_zero(mem_zero), .mem_jump(mem_jump), .mem_jreg(mem_jreg),
    .wb_Halt(wb_Halt), .pc_en(pc_en0), .pc_redirect(pc_redirect0), .ifid_en(ifid_en0),
    .idex_en(idex_en0), .exmem_en(exmem_en0), .memwb_en(memwb_en0),
    .ifid_flush(ifid_flush0), .idex_flush(idex_flush0), .exmem_flush(exmem_flush0),
    .memwb_flush(memwb_flush0), .halt(halt0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
  );

  pipeline_hazard_ctrl #(.LU_CYCLES(3), .CNT_W(4)) dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .ex_MemtoReg(ex_MemtoReg), .ex_RegWr(ex_RegWr),
    .ex_WrDest(ex_WrDest), .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_beq(mem_beq),
    .mem_bne(mem_bne), .mem_zero(mem_zero), .mem_jump(mem_jump), .mem_jreg(mem_jreg),
    .wb_Halt(wb_Halt), .pc_en(pc_en1), .pc_redirect(pc_redirect1), .ifid_en(ifid_en1),
    .idex_en(idex_en1), .exmem_en(exmem_en1), .memwb_en(memwb_en1),
    .ifid_flush(ifid_flush1), .idex_flush(idex_flush1), .exmem_flush(exmem_flush1),
    .memwb_flush(memwb_flush1), .halt(halt1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed bundle per instance: 10 enable/flush bits, halt, stall and flush counts
  logic [74:0] obs [2];
  assign obs[0] = {pc_en0, pc_redirect0, ifid_en0, idex_en0, exmem_en0, memwb_en0,
                   ifid_flush0, idex_flush0, exmem_flush0, memwb_flush0, halt0,
                   stall_cnt0, flush_cnt0};
  assign obs[1] = {pc_en1, pc_redirect1, ifid_en1, idex_en1, exmem_en1, memwb_en1,
                   ifid_flush1, idex_flush1, exmem_flush1, memwb_flush1, halt1,
                   28'd0, stall_cnt1, 28'd0, flush_cnt1};

  // Model: halted flag, waiting-for-data flag, and remaining load-use bubbles
  int     lu_of [2] = '{1, 3};
  longint cmax  [2] = '{64'hFFFF_FFFF, 64'd15};
  bit     m_halted [2];
  bit     m_dwait  [2];
  int     m_left   [2];
  longint m_stall  [2];
  longint m_flush  [2];
  logic [74:0] exp_v [2];

  localparam logic [9:0] O_ALL    = 10'b10_1111_0000;
  localparam logic [9:0] O_DFREEZE = 10'b00_0001_0001;
  localparam logic [9:0] O_REDIR  = 10'b11_1111_1110;
  localparam logic [9:0] O_LUSTL  = 10'b00_0111_0100;
  localparam logic [9:0] O_IMISS  = 10'b00_1111_1000;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_halted[k] = 1'b0; m_dwait[k] = 1'b0; m_left[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic model_step();
    bit redir, dreq, luh;
    redir = (mem_beq && mem_zero) || (mem_bne && !mem_zero) || mem_jump || mem_jreg;
    dreq  = mem_dREN || mem_dWEN;
    luh   = ex_MemtoReg && ex_RegWr && (ex_WrDest != 5'd0) &&
            ((ex_WrDest == id_rs) || (id_uses_rt && (ex_WrDest == id_rt)));
    for (int k = 0; k < 2; k++) begin
      logic [9:0] o;
      bit run, nh, nd, fl;
      int nl;
      run = !m_halted[k] && !m_dwait[k] && (m_left[k] == 0);
      o = 10'd0; nh = m_halted[k]; nd = m_dwait[k]; nl = m_left[k]; fl = 1'b0;
      if (m_halted[k]) o = 10'd0;
      else if (wb_Halt) nh = 1'b1;
      else if (m_dwait[k] || (run && dreq && !dhit)) begin
        if (m_dwait[k] && dhit) begin
          o = O_ALL; nd = 1'b0;
          if (luh) nl = lu_of[k];
        end else begin
          o = O_DFREEZE; nd = 1'b1;
        end
      end else if (redir) begin
        o = O_REDIR; nl = 0; fl = 1'b1;
      end else if (m_left[k] > 0 || luh) begin
        o = O_LUSTL;
        nl = (m_left[k] > 0) ? m_left[k] - 1 : lu_of[k] - 1;
      end else if (!ihit) o = O_IMISS;
      else o = O_ALL;
      exp_v[k] = {o, m_halted[k], 32'(m_stall[k]), 32'(m_flush[k])};
      if (RST) begin
        m_halted[k] = 1'b0; m_dwait[k] = 1'b0; m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      end else begin
        if (!o[9] && !m_halted[k] && m_stall[k] < cmax[k]) m_stall[k]++;
        if (fl && m_flush[k] < cmax[k]) m_flush[k]++;
        m_halted[k] = nh; m_dwait[k] = nd; m_left[k] = nl;
      end
    end
  endtask

  task automatic idle();
    RST = 1'b0; ihit = 1'b1; dhit = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_MemtoReg = 1'b0; ex_RegWr = 1'b0; ex_WrDest = 5'd0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
    mem_beq = 1'b0; mem_bne = 1'b0; mem_zero = 1'b0; mem_jump = 1'b0; mem_jreg = 1'b0;
    wb_Halt = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic set_lw_hazard(input logic [4:0] dest, input logic [4:0] rs);
    ex_MemtoReg = 1'b1; ex_RegWr = 1'b1; ex_WrDest = dest; id_rs = rs;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL reset_idle inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      @(negedge CLK);
    end
    vectors++;
    if (pc_en0 !== 1'b1 || ifid_flush0 !== 1'b0 || stall_cnt0 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_idle_direct: pc_en=%b ifid_flush=%b stall_cnt=%0d, required 1 0 0",
               pc_en0, ifid_flush0, stall_cnt0);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) set_lw_hazard(5'd2, 5'd2);
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL load_use inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      if (c == 0) begin
        vectors++;
        if (pc_en0 !== 1'b0 || ifid_en0 !== 1'b0 || idex_flush0 !== 1'b1) begin
          miscompares++;
          $display("FAIL load_use_stall: pc_en=%b ifid_en=%b idex_flush=%b, required 0 0 1",
                   pc_en0, ifid_en0, idex_flush0);
        end
      end
      @(negedge CLK);
    end
    vectors++;
    if (stall_cnt0 !== 32'd1 || stall_cnt1 !== 4'd3) begin
      miscompares++;
      $display("FAIL load_use_count: lu1=%0d lu3=%0d, required 1 3", stall_cnt0, stall_cnt1);
    end
  endtask

  task automatic test_lu_reg_zero();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      set_lw_hazard(5'd0, 5'd0);
      id_uses_rt = 1'b1;
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL lu_reg_zero inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      @(negedge CLK);
    end
    vectors++;
    if (stall_cnt1 !== 4'd0 || pc_en1 !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_reg_zero_direct: stall_cnt=%0d pc_en=%b, required 0 1", stall_cnt1, pc_en1);
    end
  endtask

  task automatic test_dcache_wait();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      idle();
      mem_dREN = (c < 5);
      dhit = (c == 4);
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL dcache_wait inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      vectors++;
      if ((c < 4) ? (pc_en0 !== 1'b0 || memwb_flush0 !== 1'b1 || exmem_en0 !== 1'b0)
                  : (pc_en0 !== 1'b1 || memwb_flush0 !== 1'b0 || exmem_en0 !== 1'b1)) begin
        miscompares++;
        $display("FAIL dcache_wait_direct cyc%0d: pc_en=%b memwb_flush=%b exmem_en=%b",
                 c, pc_en0, memwb_flush0, exmem_en0);
      end
      @(negedge CLK);
    end
    vectors++;
    if (stall_cnt0 !== 32'd4) begin
      miscompares++;
      $display("FAIL dcache_wait_count: got %0d required 4", stall_cnt0);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 0) begin
        mem_beq = 1'b1; mem_zero = 1'b1; ihit = 1'b0;
        set_lw_hazard(5'd7, 5'd7);
      end
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL redirect inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      vectors++;
      if ((c == 0) ? (pc_redirect1 !== 1'b1 || pc_en1 !== 1'b1 || ifid_flush1 !== 1'b1 ||
                      idex_flush1 !== 1'b1 || exmem_flush1 !== 1'b1)
                   : (pc_redirect1 !== 1'b0 || pc_en1 !== 1'b1 || flush_cnt1 !== 4'd1)) begin
        miscompares++;
        $display("FAIL redirect_direct cyc%0d: redirect=%b pc_en=%b flush_cnt=%0d",
                 c, pc_redirect1, pc_en1, flush_cnt1);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_halt(input bit during_dwait);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      idle();
      if (during_dwait) mem_dREN = (c < 4);
      wb_Halt = (c == 2);
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL halt%0d inst%0d cyc%0d: got %h expected %h", during_dwait, k, c, obs[k], exp_v[k]);
        end
      end
      vectors++;
      if (halt0 !== (c > 2) || (c >= 2 && (memwb_en0 !== 1'b0 || pc_en0 !== 1'b0))) begin
        miscompares++;
        $display("FAIL halt_direct%0d cyc%0d: halt=%b memwb_en=%b pc_en=%b",
                 during_dwait, c, halt0, memwb_en0, pc_en0);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c == 0) set_lw_hazard(5'd3, 5'd3);
      RST = (c == 1);
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL reset_mid inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      @(negedge CLK);
    end
    vectors++;
    if (stall_cnt1 !== 4'd0 || pc_en1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_direct: stall_cnt=%0d pc_en=%b, required 0 1", stall_cnt1, pc_en1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      RST = ($urandom_range(79) == 0);
      ihit = ($urandom_range(3) != 0);
      dhit = ($urandom_range(2) == 0);
      id_rs = 5'($urandom_range(3));
      id_rt = 5'($urandom_range(3));
      id_uses_rt = 1'($urandom);
      ex_MemtoReg = 1'($urandom);
      ex_RegWr = ($urandom_range(3) != 0);
      ex_WrDest = 5'($urandom_range(3));
      mem_dREN = ($urandom_range(4) == 0);
      mem_dWEN = ($urandom_range(8) == 0);
      mem_beq = ($urandom_range(7) == 0);
      mem_bne = ($urandom_range(9) == 0);
      mem_zero = 1'($urandom);
      mem_jump = ($urandom_range(19) == 0);
      mem_jreg = ($urandom_range(24) == 0);
      wb_Halt = ($urandom_range(149) == 0);
      #1 model_step();
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (obs[k] !== exp_v[k]) begin
          miscompares++;
          $display("FAIL random inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_v[k]);
        end
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_reset();
    test_reset();
    test_load_use();
    test_lu_reg_zero();
    test_dcache_wait();
    test_redirect();
    test_halt(1'b0);
    test_halt(1'b1);
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Consumer end of the pipeline register interface: reads the stage fields (ID rs/rt, EX load/WrDest, MEM branch/jump/memory controls, WB Halt) and produces per-stage enable/flush, PC control and halt for the 5-stage MIPS pipeline.
- Owns the pipeline's stall/flush sequencing: data-cache wait, load-use stall (multi-cycle capable), control redirect flush, icache miss bubbles, and sticky halt.
- Keeps 32-bit stall/flush event counters for bench and performance observation.

Parameters:
- LU_CYCLES, 1, bubbles inserted per load-use hazard (1..7; >1 for no-forwarding builds).
- CNT_W, 32, width of the event counters.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_MemtoReg, ex_RegWr  in  1 each  ID/EX instruction is a load / writes a register.
- ex_WrDest  in  5  ID/EX destination register.
- mem_dREN, mem_dWEN  in  1 each  EX/MEM instruction reads/writes dmem.
- mem_beq, mem_bne, mem_zero, mem_jump, mem_jreg  in  1 each  EX/MEM control fields.
- wb_Halt  in  1  MEM/WB holds halt.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC takes the MEM-stage target instead of npc.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all fields 0) when the stage enable is also 1.
- halt  out  1  registered, sticky.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

Behaviour:
- Reset: state=RUN, lu_cnt=0, halt=0, both counters=0. All enable outputs are combinational from state and inputs. RST has priority over everything.
- States: RUN, DWAIT, LUSTALL, HALTED.
- redirect = (mem_beq & mem_zero) | (mem_bne & ~mem_zero) | mem_jump | mem_jreg.
- dreq = mem_dREN | mem_dWEN.
- lu_haz = ex_MemtoReg & ex_RegWr & (ex_WrDest != 0) & ((ex_WrDest == id_rs) | (id_uses_rt & ex_WrDest == id_rt)).
- Outputs are evaluated in priority order; the first match applies:
  - HALTED: all enables 0, all flushes 0, pc_en 0, halt 1. Only RST exits.
  - wb_Halt (any state except HALTED): all enables 0. Next state is HALTED and halt=1 from the next cycle.
  - DWAIT, or RUN with dreq & ~dhit: pc_en, ifid_en, idex_en and exmem_en are 0; memwb_en=1 with memwb_flush=1. Next state is DWAIT until dhit=1. In the dhit cycle all stages advance normally and next state is RUN (or LUSTALL if lu_haz also holds).
  - redirect: pc_en=1, pc_redirect=1, all enables 1, ifid_flush=idex_flush=exmem_flush=1. This overrides lu_haz, LUSTALL and ~ihit. lu_cnt clears; next state is RUN. flush_cnt increments.
  - LUSTALL, or RUN with lu_haz: pc_en=0, ifid_en=0, idex_flush=1, later stages advance.
    - Entering from RUN loads lu_cnt=LU_CYCLES-1. With LU_CYCLES=1, next state stays RUN.
    - In LUSTALL, lu_cnt decrements each cycle and the state returns to RUN when lu_cnt reaches 0 on that edge.
  - ~ihit: pc_en=0, ifid_en=1 with ifid_flush=1, later stages advance.
  - Otherwise all enables 1, flushes 0, pc_en=1.
- pc_redirect is 0 whenever the redirect row is not selected.
- stall_cnt increments on every cycle in which pc_en=0 and state is not HALTED.
- Both counters saturate at all-ones and do not wrap.
- Register 0 never produces lu_haz.
- RST asserted in any state, including mid-DWAIT or mid-LUSTALL, returns to the reset values on the next edge.

Test Plan:
- RST, then ihit=1 with no hazards for 5 cycles -> all enables 1, flushes 0, pc_en 1, stall_cnt=0.
- lw $2 in EX (ex_WrDest=2) with ID add reading rs=2, LU_CYCLES=1 -> exactly 1 cycle of pc_en=0, ifid_en=0, idex_flush=1; then normal; stall_cnt=1.
- LU_CYCLES=3, same hazard -> 3 consecutive stall cycles; stall_cnt=3.
- LU_CYCLES=3, ex_WrDest=0 -> no stall.
- mem_dREN=1 with dhit low for 4 cycles then high -> 4 cycles frozen with memwb_flush=1, advance on the 5th; DWAIT→RUN.
- mem_beq=1, mem_zero=1 while ihit=0 and lu_haz=1 -> pc_redirect=1, pc_en=1, three flushes, flush_cnt=1, state RUN, lu_cnt=0.
- wb_Halt pulse -> halt=1 the next cycle and stays 1 with all enables 0 until RST.
- wb_Halt during DWAIT -> HALTED.
